// File: rtl/stack_pkg.sv
// Shared definitions for the return-address stack front-end controller:
// geometry constants, FSM state encoding, per-port op decoding and a helper
// that maps an occupancy count onto its FSM state.
package stack_pkg;

  localparam int STK_DEPTH = 8;
  localparam int STK_DW    = 12;
  localparam int STK_CW    = $clog2(STK_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } op_t;

  // Push wins over pop when a port raises both; that is not an error.
  function automatic op_t port_op(input logic push, input logic pop);
    if (push) return OP_PUSH;
    if (pop)  return OP_POP;
    return OP_NONE;
  endfunction

  // Occupancy state implied by a count (never returns ST_FAULT).
  function automatic state_t state_from_count(input int unsigned cnt,
                                              input int unsigned depth);
    if (cnt == 0)     return ST_EMPTY;
    if (cnt >= depth) return ST_FULL;
    return ST_PARTIAL;
  endfunction

endpackage

// File: rtl/stack_arb2.sv
// Two-port arbiter for the stack front end.
// STACK_ARB_RR_EN defined : round-robin; the pointer names the favoured port and
//                           flips to the other port after every grant.
// STACK_ARB_RR_EN undefined: fixed priority, port 1 (interrupt/trap) always wins.
module stack_arb2 (
`ifdef STACK_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic i_upd,
`endif
  input  logic i_req0,
  input  logic i_req1,
  output logic o_valid,
  output logic o_sel
);

  assign o_valid = i_req0 | i_req1;

`ifdef STACK_ARB_RR_EN
  logic r_ptr;

  // Pick the favoured port on contention, otherwise whichever port is asking.
  always_comb begin
    if (i_req0 && i_req1) o_sel = r_ptr;
    else                  o_sel = i_req1;
  end

  // Hand priority to the other port after each grant, faulting grants included.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst)                    r_ptr <= 1'b0;
    else if (i_upd && o_valid)  r_ptr <= ~o_sel;
  end
`else
  // Port 1 wins whenever it requests.
  always_comb begin
    o_sel = i_req1;
  end
`endif

endmodule

// File: rtl/stack_arbiter_ctrl.sv
// Front-end controller for the 8-entry, 12-bit return-address stack.
// Arbitrates CPU (port 0) and interrupt/trap (port 1) push/pop requests, blocks
// illegal ops, tracks occupancy and latches a sticky fault until clr_fault.
// Build option: STACK_ARB_RR_EN selects round-robin arbitration (see stack_arb2).
module stack_arbiter_ctrl
  import stack_pkg::*;
#(
  parameter int DEPTH = STK_DEPTH,
  parameter int DW    = STK_DW,
  parameter int CW    = STK_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_push,
  input  logic          req0_pop,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_push,
  input  logic          req1_pop,
  input  logic [DW-1:0] req1_wdata,
  output logic          gnt0,
  output logic          gnt1,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_wdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          fault,
  output logic          fault_src,
  input  logic          clr_fault
);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_fault;
  logic          r_fault_src;

  op_t           w_op0;
  op_t           w_op1;
  op_t           w_op;
  logic          w_req0;
  logic          w_req1;
  logic          w_any;
  logic          w_sel;
  logic          w_active;
  logic          w_legal;
  logic [DW-1:0] w_wdata;
  logic [CW-1:0] w_count_nxt;

  assign w_op0  = port_op(req0_push, req0_pop);
  assign w_op1  = port_op(req1_push, req1_pop);
  assign w_req0 = (w_op0 != OP_NONE);
  assign w_req1 = (w_op1 != OP_NONE);

  stack_arb2 u_arb (
`ifdef STACK_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .i_upd   (w_active),
`endif
    .i_req0  (w_req0),
    .i_req1  (w_req1),
    .o_valid (w_any),
    .o_sel   (w_sel)
  );

  // A grant is issued only outside FAULT and never while reset is asserted.
  assign w_active = w_any && (r_state != ST_FAULT) && !rst;
  assign w_op     = w_sel ? w_op1 : w_op0;
  assign w_wdata  = w_sel ? req1_wdata : req0_wdata;

  // Decide legality of the winning op and the occupancy it would produce.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    w_legal     = 1'b0;
    w_count_nxt = r_count;
    case (w_op)
      OP_PUSH: begin
        w_legal     = (r_count < CW'(DEPTH));
        w_count_nxt = r_count + CW'(1);
      end
      OP_POP: begin
        w_legal     = (r_count != '0);
        w_count_nxt = r_count - CW'(1);
      end
      default: begin
        w_legal     = 1'b0;
        w_count_nxt = r_count;
      end
    endcase
  end

  // The winning port is always acknowledged, even for an illegal (consumed) op;
  // only legal ops reach the stack.
  assign gnt0      = w_active && !w_sel;
  assign gnt1      = w_active &&  w_sel;
  assign stk_push  = w_active && w_legal && (w_op == OP_PUSH);
  assign stk_pop   = w_active && w_legal && (w_op == OP_POP);
  assign stk_wdata = stk_push ? w_wdata : '0;

  // Occupancy FSM: count, state and the sticky fault all update here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_fault     <= 1'b0;
      r_fault_src <= 1'b0;
    end else begin
      case (r_state)
        ST_FAULT: begin
          // Count is frozen; leaving FAULT re-derives the occupancy state.
          if (clr_fault) begin
            r_state <= state_from_count(int'(r_count), DEPTH);
            r_fault <= 1'b0;
          end
        end
        default: begin
          if (w_active) begin
            if (!w_legal) begin
              r_state     <= ST_FAULT;
              r_fault     <= 1'b1;
              r_fault_src <= w_sel;
            end else begin
              r_count <= w_count_nxt;
              r_state <= state_from_count(int'(w_count_nxt), DEPTH);
              r_full  <= (w_count_nxt == CW'(DEPTH));
              r_empty <= (w_count_nxt == '0);
            end
          end
        end
      endcase
    end
  end

  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign fault     = r_fault;
  assign fault_src = r_fault_src;

endmodule
